// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the 7-segment scan controller.
package seg_scan_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {ST_OFF, ST_BLANK, ST_SHOW} scan_st_e;

  // Selects hex nibble i from a packed value of up to 8 digits.
  function automatic logic [3:0] nib_sel(input logic [31:0] d, input logic [2:0] i);
    return d[{i, 2'b00} +: 4];
  endfunction
endpackage

// File: rtl/hex7seg.sv
// Hex nibble to active-low 7-segment pattern, bit order gfedcba.
module hex7seg (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'h7F;
    endcase
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-seg scanner with frame-aligned double buffering.
// Define SEG_LZB_EN to blank leading zero digits.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NDIG  = 4,
  parameter int DIV   = 50000,
  parameter int BLANK = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] in_data,
  input  logic [NDIG-1:0]   in_dp,
  output logic [NDIG-1:0]   an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic              frame_done
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [4*NDIG-1:0] pend_d, act_d;
  logic [NDIG-1:0]   pend_p, act_p;
  logic              pend_full;
  scan_st_e          st;
  logic              frame_end, xfer, load_act;
  logic [31:0]       act32;
  logic [2:0]        idx3;
  logic [3:0]        nib;
  logic [6:0]        dec_seg, shw_seg;

  assign frame_end = en && (cnt == CW'(DIV - 1)) && (idx == IW'(NDIG - 1));
  assign in_ready  = !pend_full || frame_end;
  assign xfer      = in_valid && in_ready;
  // While dark there is nothing to tear, so pending is promoted immediately.
  assign load_act  = pend_full && (frame_end || !en);

  always_comb begin
    st = ST_OFF;
    if (en) st = (cnt < CW'(BLANK)) ? ST_BLANK : ST_SHOW;
  end

  assign act32 = 32'(act_d);
  assign idx3  = 3'(idx);
  assign nib   = nib_sel(act32, idx3);

  hex7seg u_dec (.nib(nib), .seg(dec_seg));

`ifdef SEG_LZB_EN
  always_comb begin
    shw_seg = dec_seg;
    if ((idx != '0) && ((act32 >> {idx3, 2'b00}) == 32'd0)) shw_seg = SEG_BLANK;
  end
`else
  assign shw_seg = dec_seg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_d    <= '0;
      pend_p    <= '0;
      pend_full <= 1'b0;
      act_d     <= '0;
      act_p     <= '0;
    end else begin
      if (load_act) begin
        act_d     <= pend_d;
        act_p     <= pend_p;
        pend_full <= 1'b0;
      end
      if (xfer) begin
        pend_d    <= in_data;
        pend_p    <= in_dp;
        pend_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      an         <= '1;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      an         <= '1;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      case (st)
        ST_OFF: begin
          cnt <= '0;
          idx <= '0;
        end
        ST_BLANK, ST_SHOW: begin
          if (st == ST_SHOW) begin
            an  <= ~(NDIG'(1) << idx);
            seg <= shw_seg;
            dp  <= ~act_p[idx];
          end
          if (cnt == CW'(DIV - 1)) begin
            cnt <= '0;
            idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt <= '0;
          idx <= '0;
        end
      endcase
    end
  end
endmodule
